mul8_seq_arbiter: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 20 ++
 rtl/mul4.sv | 21 ++
 rtl/mul8_seq_arbiter.sv | 123 ++++++++++++
 tb/tb_mul8_seq_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequenced 8x8 multiplier built on a 4x4 core.
// Step k feeds nibble pair k to the core; STEP_SHIFT[k] aligns that partial product.
package mul_seq_pkg;

    localparam int OPW   = 8;
    localparam int NIBW  = 4;
    localparam int PRODW = 16;

    localparam logic [1:0] STEP_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Indexed by step: lo*lo, hi*lo, lo*hi, hi*hi.
    localparam logic [3:0][3:0] STEP_SHIFT = {4'd8, 4'd4, 4'd4, 4'd0};

endpackage

// File: rtl/mul4.sv
// Combinational 4x4 unsigned array multiplier: one shifted AND-row per bit of b.
module mul4
    import mul_seq_pkg::*;
(
    input  logic [NIBW-1:0]   a_i,
    input  logic [NIBW-1:0]   b_i,
    output logic [2*NIBW-1:0] p_o
);

    // NOTE: blocking assignments inside always_comb, so each row adds onto the
    // running sum left by the previous row within the same evaluation.
    always_comb begin
        p_o = '0;
        for (int row = 0; row < NIBW; row++) begin
            if (b_i[row]) begin
                p_o = p_o + ({{NIBW{1'b0}}, a_i} << row);
            end
        end
    end

endmodule

// File: rtl/mul8_seq_arbiter.sv
// Two-requester round-robin front end that builds 8x8 products from four passes
// through one shared 4x4 multiplier and returns them on a backpressured port.
module mul8_seq_arbiter
    import mul_seq_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OPW-1:0]   req_a,
    input  logic [NREQ*OPW-1:0]   req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_id,
    output logic [PRODW-1:0]      res_product,
    output logic                  busy
);

    state_e           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [PRODW-1:0] acc_q, acc_d;
    logic [PRODW-1:0] prod_q, prod_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;

    logic             grant;
    logic [NIBW-1:0]  a_nib;
    logic [NIBW-1:0]  b_nib;
    logic [2*NIBW-1:0] pp;
    logic [PRODW-1:0] acc_sum;

    // Under contention the requester not served last wins; otherwise whoever is valid.
    assign grant = (&req_valid) ? ~last_grant_q : req_valid[1];

    // Step bit 0 picks the high nibble of a, step bit 1 the high nibble of b.
    assign a_nib = step_q[0] ? a_q[OPW-1:NIBW] : a_q[NIBW-1:0];
    assign b_nib = step_q[1] ? b_q[OPW-1:NIBW] : b_q[NIBW-1:0];

    mul4 u_mul4 (
        .a_i (a_nib),
        .b_i (b_nib),
        .p_o (pp)
    );

    assign acc_sum = acc_q + ({{(PRODW-2*NIBW){1'b0}}, pp} << STEP_SHIFT[step_q]);

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        acc_d        = acc_q;
        prod_d       = prod_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;
        res_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid[grant]) begin
                    req_ready[grant] = 1'b1;
                    a_d          = grant ? req_a[2*OPW-1:OPW] : req_a[OPW-1:0];
                    b_d          = grant ? req_b[2*OPW-1:OPW] : req_b[OPW-1:0];
                    id_d         = grant;
                    last_grant_d = grant;
                    acc_d        = '0;
                    step_d       = '0;
                    state_d      = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (step_q == STEP_LAST) begin
                    prod_d  = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            step_q       <= '0;
            acc_q        <= '0;
            prod_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            prod_q       <= prod_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // The product register only loads on entry to DONE, so it holds through MUL.
    assign res_product = prod_q;
    assign res_id      = id_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mul8_seq_arbiter.sv
// Self-checking bench: a cycle-level reference model at negedge predicts
// handshakes and response timing; a scoreboard queue holds expected products.
module tb_mul8_seq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic        res_id;
    logic [15:0] res_product;
    logic        busy;

    always #5 clk = ~clk;

    mul8_seq_arbiter #(.NREQ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_product (res_product),
        .busy        (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        id;
        logic [15:0] prod;
    } exp_t;

    typedef enum {M_IDLE, M_MUL, M_DONE} mstate_e;

    exp_t    sb[$];
    int      hs_log_id[$];
    int      hs_log_cyc[$];
    int      cyc    = 0;
    int      hs_cyc = 0;
    int      n_push = 0;
    mstate_e m_state = M_IDLE;
    int      m_step  = 0;
    logic    m_last  = 1'b1;
    logic    prev_rv = 1'b0;
    logic [1:0] m_exp_ready;
    logic    m_g;
    logic    m_hs;
    exp_t    m_e;

    // Reference model and scoreboard, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_state = M_IDLE;
            m_step  = 0;
            m_last  = 1'b1;
            sb.delete();
            check("rst_res_valid",   32'(res_valid),   32'(0));
            check("rst_busy",        32'(busy),        32'(0));
            check("rst_res_id",      32'(res_id),      32'(0));
            check("rst_res_product", 32'(res_product), 32'(0));
            check("rst_req_ready",   32'(req_ready),   32'(0));
            prev_rv = res_valid;
        end else begin
            m_exp_ready = 2'b00;
            m_hs        = 1'b0;
            m_g         = (req_valid == 2'b11) ? ~m_last : req_valid[1];
            if (m_state == M_IDLE && req_valid[m_g]) begin
                m_exp_ready[m_g] = 1'b1;
                m_hs             = 1'b1;
            end
            check("req_ready",      32'(req_ready),              32'(m_exp_ready));
            check("grant_to_valid", 32'(req_ready & ~req_valid), 32'(0));
            check("busy",           32'(busy),                   32'(m_state != M_IDLE));
            check("res_valid",      32'(res_valid),              32'(m_state == M_DONE));
            if (res_valid && !prev_rv) begin
                check("latency_edges", 32'(cyc - hs_cyc - 1), 32'(4));
            end
            prev_rv = res_valid;
            if (m_state == M_DONE && sb.size() > 0) begin
                check("res_id",      32'(res_id),      32'(sb[0].id));
                check("res_product", 32'(res_product), 32'(sb[0].prod));
            end
            case (m_state)
                M_IDLE: begin
                    if (m_hs) begin
                        m_e.id   = m_g;
                        m_e.prod = 16'(m_g ? req_a[15:8] : req_a[7:0]) *
                                   16'(m_g ? req_b[15:8] : req_b[7:0]);
                        sb.push_back(m_e);
                        n_push++;
                        m_last  = m_g;
                        m_state = M_MUL;
                        m_step  = 0;
                        hs_cyc  = cyc;
                        hs_log_id.push_back(int'(m_g));
                        hs_log_cyc.push_back(cyc);
                    end
                end
                M_MUL: begin
                    if (m_step == 3) m_state = M_DONE;
                    else m_step++;
                end
                M_DONE: begin
                    if (res_ready) begin
                        void'(sb.pop_front());
                        m_state = M_IDLE;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        res_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic do_req(input int id, input logic [7:0] a, input logic [7:0] b);
        bit accepted = 1'b0;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid[id]    = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = req_ready[id];
            tick();
        end
        req_valid[id] = 1'b0;
        if (!accepted) check("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic expect_result(input logic id, input logic [15:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1'b1;
                check("dir_res_id",      32'(res_id),      32'(id));
                check("dir_res_product", 32'(res_product), 32'(exp));
            end
            tick();
        end
        if (!seen) check("result_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
        do_req(id, a, b);
        expect_result(1'(id), exp);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 30 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
            tick();
        end
        if (!idle) check("idle_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int base;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        apply_reset();

        // First request and corner operands.
        run_one(0, 8'h0F, 8'h0F, 16'h00E1);
        run_one(0, 8'hFF, 8'hFF, 16'hFE01);
        run_one(1, 8'h00, 8'hA5, 16'h0000);
        run_one(0, 8'h10, 8'h10, 16'h0100);
        run_one(1, 8'h12, 8'h34, 16'h03A8);

        // Sustained contention from a fresh reset: strict alternation, 6 cycles apart.
        apply_reset();
        hs_log_id.delete();
        hs_log_cyc.delete();
        req_a     = {8'd7, 8'd3};
        req_b     = {8'd9, 8'd5};
        req_valid = 2'b11;
        for (int i = 0; i < 60 && hs_log_id.size() < 4; i++) tick();
        req_valid = 2'b00;
        check("alt_count", 32'(hs_log_id.size()), 32'(4));
        for (int i = 0; i < 4 && i < hs_log_id.size(); i++) begin
            check("alt_id", 32'(hs_log_id[i]), 32'(i % 2));
            if (i > 0) check("alt_spacing", 32'(hs_log_cyc[i] - hs_log_cyc[i-1]), 32'(6));
        end
        wait_idle();

        // Backpressure with a competing request held valid through MUL and DONE.
        res_ready = 1'b0;
        do_req(1, 8'h12, 8'h34);
        req_a[7:0]   = 8'd2;
        req_b[7:0]   = 8'd3;
        req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
            if (!seen) tick();
        end
        if (!seen) check("bp_timeout", 32'(0), 32'(1));
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("bp_valid",   32'(res_valid),   32'(1));
            check("bp_id",      32'(res_id),      32'(1));
            check("bp_product", 32'(res_product), 32'(16'h03A8));
            check("bp_ready",   32'(req_ready),   32'(0));
        end
        tick();
        res_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_release_busy",  32'(busy),      32'(0));
        check("bp_release_ready", 32'(req_ready), 32'(2'b01));
        tick();
        req_valid[0] = 1'b0;
        expect_result(1'b0, 16'd6);

        // Reset during MUL step 2 drops the in-flight request.
        do_req(0, 8'hAB, 8'hCD);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_res_valid",   32'(res_valid),   32'(0));
        check("midrst_busy",        32'(busy),        32'(0));
        check("midrst_res_product", 32'(res_product), 32'(0));
        check("midrst_res_id",      32'(res_id),      32'(0));
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_result", 32'(res_valid), 32'(0));
            tick();
        end
        run_one(1, 8'h55, 8'h66, 16'h21DE);

        // Random sweep: operands, valids and consumer readiness all vary per cycle.
        base = n_push;
        for (int i = 0; i < 30000 && n_push < base + 1000; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        check("sweep_accepts", 32'(n_push - base >= 1000), 32'(1));
        req_valid = 2'b00;
        res_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("drain_busy",      32'(busy),      32'(0));
        check("drain_res_valid", 32'(res_valid), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
